// File: rtl/lfsr_rr_word_server_pkg.sv
// Shared definitions for the LFSR word server and future LFSR consumers:
// controller states, default seed, feedback taps and a width helper.
package lfsr_rr_word_server_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_IDLE,
    ST_SHIFT,
    ST_RESP
  } srv_state_t;

  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h150F_2464;

  // x^32 + x^22 + x^2 + x + 1 expressed as a mask over the shift register bits
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      bits++;
    end
    return bits;
  endfunction

endpackage

// File: rtl/lfsr_rr_word_server_arb.sv
// Combinational round-robin arbiter: grants the first set request at or
// after the pointer. The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx
);

  logic [ID_W-1:0] pos;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = ID_W'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/lfsr_rr_word_server_lfsr.sv
// Serial Fibonacci LFSR: shifts every clock, parallel seed load, MSB is the
// serial output.
module linear_feedback_shift_register
  import lfsr_rr_word_server_pkg::*;
#(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(LFSR_TAPS_32)
) (
  output logic             q,
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             load
);

  logic [WIDTH-1:0] sr;

  // All-ones keeps the register out of the all-zero lock state until a seed arrives
  always_ff @(posedge clock) begin
    if (rst) begin
      sr <= '1;
    end else if (load) begin
      sr <= seed;
    end else begin
      sr <= {sr[WIDTH-2:0], ^(sr & TAPS)};
    end
  end

  assign q = sr[WIDTH-1];

endmodule

// File: rtl/lfsr_rr_word_server.sv
// Shares one serial LFSR between NUM_REQ requesters: round-robin grant,
// WORD_W-bit word collection (first bit in MSB), and reseeding via the load port.
module lfsr_rr_word_server
  import lfsr_rr_word_server_pkg::*;
#(
  parameter int unsigned        NUM_REQ      = 4,
  parameter int unsigned        WORD_W       = 32,
  parameter int unsigned        SEED_W       = 32,
  parameter logic [SEED_W-1:0]  DEFAULT_SEED = SEED_W'(LFSR_DEFAULT_SEED),
  parameter logic [SEED_W-1:0]  LFSR_TAPS    = SEED_W'(LFSR_TAPS_32),
  localparam int unsigned       ID_W         = ceil_log2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               cfg_seed_valid,
  input  logic [SEED_W-1:0]  cfg_seed,
  output logic               cfg_seed_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORD_W-1:0]  rsp_word,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy,
  output logic               seed_zero_err
);

  localparam int unsigned CNT_W = ceil_log2(WORD_W);

  srv_state_t          state;
  logic [SEED_W-1:0]   seed_q;
  logic [ID_W-1:0]     ptr;
  logic [CNT_W-1:0]    cnt;
  logic                lfsr_q;
  logic                lfsr_load;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;

  assign lfsr_load = (state == ST_LOAD);

  linear_feedback_shift_register #(
    .WIDTH (SEED_W),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .q     (lfsr_q),
    .clock (clock),
    .rst   (rst),
    .seed  (seed_q),
    .load  (lfsr_load)
  );

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state          <= ST_LOAD;
      seed_q         <= DEFAULT_SEED;
      ptr            <= '0;
      cnt            <= '0;
      rsp_word       <= '0;
      rsp_id         <= '0;
      rsp_valid      <= 1'b0;
      busy           <= 1'b1;
      cfg_seed_ready <= 1'b0;
      seed_zero_err  <= 1'b0;
    end else begin
      seed_zero_err <= 1'b0;
      case (state)
        ST_LOAD: begin
          state          <= ST_IDLE;
          cfg_seed_ready <= 1'b1;
          busy           <= 1'b0;
        end
        ST_IDLE: begin
          // Reseed wins over a pending request; the request is served after LOAD
          if (cfg_seed_valid) begin
            state          <= ST_LOAD;
            cfg_seed_ready <= 1'b0;
            busy           <= 1'b1;
            if (cfg_seed == '0) begin
              seed_q        <= DEFAULT_SEED;
              seed_zero_err <= 1'b1;
            end else begin
              seed_q <= cfg_seed;
            end
          end else if (|gnt) begin
            state          <= ST_SHIFT;
            cfg_seed_ready <= 1'b0;
            busy           <= 1'b1;
            rsp_id         <= gnt_idx;
            cnt            <= '0;
            ptr            <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        ST_SHIFT: begin
          rsp_word <= {rsp_word[WORD_W-2:0], lfsr_q};
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_W'(WORD_W - 1)) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state          <= ST_IDLE;
            rsp_valid      <= 1'b0;
            cfg_seed_ready <= 1'b1;
            busy           <= 1'b0;
          end
        end
        default: begin
          state <= ST_LOAD;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rr_word_server.sv
// Scoreboard bench for lfsr_rr_word_server: a transaction-level reference
// model predicts each response word; a negedge monitor compares and pops.
module tb_lfsr_rr_word_server;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;
  localparam logic [31:0] DEF_SEED = 32'h150F2464;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0001;
  logic        cfg_seed_valid = 1'b0;
  logic [31:0] cfg_seed = '0;
  logic        cfg_seed_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_word;
  logic [1:0]  rsp_id;
  logic        busy;
  logic        seed_zero_err;

  always #5 clock = ~clock;

  lfsr_rr_word_server #(
    .NUM_REQ (N),
    .WORD_W  (W),
    .SEED_W  (32)
  ) dut (
    .clock          (clock),
    .rst            (rst),
    .req            (req),
    .cfg_seed_valid (cfg_seed_valid),
    .cfg_seed       (cfg_seed),
    .cfg_seed_ready (cfg_seed_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_word       (rsp_word),
    .rsp_id         (rsp_id),
    .busy           (busy),
    .seed_zero_err  (seed_zero_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] word;
    int          id;
    int          grant_edge;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_lfsr = '0;
  logic [31:0] m_seed = DEF_SEED;
  logic [31:0] m_word = '0;
  bit          m_rst = 1'b1;
  bit          m_loading = 1'b1;
  bit          m_idle = 1'b0;
  bit          m_resp = 1'b0;
  bit          m_err = 1'b0;
  int          m_shift_left = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  int          m_edge = 0;
  int          m_grant_edge = 0;
  int          m_handshakes = 0;
  int          m_seed_accepts = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  always @(posedge clock) begin : model
    logic old_q;
    bit   found;
    int   idx;
    m_edge++;
    m_err = 1'b0;
    m_rst = rst;
    if (rst) begin
      m_loading    = 1'b1;
      m_idle       = 1'b0;
      m_resp       = 1'b0;
      m_shift_left = 0;
      m_ptr        = 0;
      m_seed       = DEF_SEED;
      sb.delete();
    end else begin
      old_q  = m_lfsr[31];
      m_lfsr = m_loading ? m_seed : lfsr_next(m_lfsr);
      if (m_loading) begin
        m_loading = 1'b0;
        m_idle    = 1'b1;
      end else if (m_idle) begin
        if (cfg_seed_valid) begin
          m_err     = (cfg_seed == 32'd0);
          m_seed    = m_err ? DEF_SEED : cfg_seed;
          m_idle    = 1'b0;
          m_loading = 1'b1;
          m_seed_accepts++;
        end else if (req != 4'd0) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && req[idx]) begin
              found = 1'b1;
              m_id  = idx;
            end
          end
          m_ptr        = (m_id + 1) % N;
          m_idle       = 1'b0;
          m_shift_left = W;
          m_word       = '0;
          m_grant_edge = m_edge;
        end
      end else if (m_shift_left > 0) begin
        m_word = {m_word[30:0], old_q};
        m_shift_left--;
        if (m_shift_left == 0) begin
          m_resp = 1'b1;
          sb.push_back('{word: m_word, id: m_id, grant_edge: m_grant_edge});
        end
      end else if (m_resp && rsp_ready) begin
        m_resp = 1'b0;
        m_idle = 1'b1;
        m_handshakes++;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] hs_words[$];
  int          hs_ids[$];
  bit          prev_valid = 1'b0;
  bit          chk_period = 1'b0;
  int          prev_rise = -1;

  always @(negedge clock) begin : monitor
    if (m_edge > 0) begin
      if (m_rst) begin
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 1);
        check("reset_cfg_seed_ready", cfg_seed_ready, 0);
        check("reset_rsp_word", rsp_word, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_seed_zero_err", seed_zero_err, 0);
        prev_valid = 1'b0;
      end else begin
        check("rsp_valid", rsp_valid, m_resp);
        check("busy", busy, !m_idle);
        check("cfg_seed_ready", cfg_seed_ready, m_idle);
        check("seed_zero_err", seed_zero_err, m_err);
        if (rsp_valid && sb.size() > 0) begin
          check("rsp_word", rsp_word, sb[0].word);
          check("rsp_id", rsp_id, sb[0].id);
          if (!prev_valid) begin
            check("latency", (m_edge + 1) - sb[0].grant_edge, W + 1);
            if (chk_period && prev_rise >= 0) check("period", m_edge - prev_rise, W + 2);
            prev_rise = m_edge;
          end
          if (rsp_ready && !rst) begin
            hs_words.push_back(rsp_word);
            hs_ids.push_back(int'(rsp_id));
            void'(sb.pop_front());
          end
        end
        prev_valid = rsp_valid;
      end
      if (!chk_period) prev_rise = -1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  function automatic bit cond(input int kind, input int arg);
    case (kind)
      0:       return m_handshakes >= arg;
      1:       return m_shift_left == arg;
      2:       return m_idle && sb.size() == 0;
      3:       return m_seed_accepts >= arg;
      4:       return m_resp;
      default: return m_shift_left > 0;
    endcase
  endfunction

  task automatic wait_until(input string what, input int kind, input int arg);
    int n = 0;
    while (!cond(kind, arg) && n < 500) begin
      tick();
      n++;
    end
    check({"wait_", what}, cond(kind, arg), 1);
  endtask

  int base;

  initial begin
    // 1: reset with requester 0 held; first word and latency
    tick(3);
    rst = 1'b0;
    wait_until("first_word", 0, 1);
    req = 4'b0000;
    wait_until("idle1", 2, 0);

    // 2: all requesters, back-to-back service from a fresh pointer
    rst = 1'b1;
    req = 4'b1111;
    tick(2);
    rst = 1'b0;
    base = m_handshakes;
    chk_period = 1'b1;
    wait_until("rr_five", 0, base + 5);
    chk_period = 1'b0;
    for (int k = 0; k < 5; k++) check("rr_order", hs_ids[base + k], k % 4);
    req = 4'b0000;
    wait_until("idle2", 2, 0);

    // 3: backpressure holds the response stable
    rsp_ready = 1'b0;
    req = 4'b0001;
    wait_until("resp3", 4, 0);
    req = 4'b0000;
    tick(10);
    rsp_ready = 1'b1;
    wait_until("idle3", 2, 0);

    // 4: reseed requested mid-word waits for IDLE
    req = 4'b0001;
    wait_until("shift4", 5, 0);
    base = m_seed_accepts;
    cfg_seed = 32'hDEADBEEF;
    cfg_seed_valid = 1'b1;
    wait_until("seed4", 3, base + 1);
    cfg_seed_valid = 1'b0;
    base = m_handshakes;
    wait_until("word4", 0, base + 1);
    req = 4'b0000;
    wait_until("idle4", 2, 0);

    // 5: zero seed is replaced by the default
    cfg_seed = 32'd0;
    cfg_seed_valid = 1'b1;
    tick();
    cfg_seed_valid = 1'b0;
    tick(3);

    // 6: reset mid-word abandons it; next word repeats the first one
    req = 4'b0001;
    wait_until("shift6", 1, W - 15);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    base = m_handshakes;
    wait_until("word6", 0, base + 1);
    check("repeat_word", hs_words[base], hs_words[0]);
    check("repeat_id", hs_ids[base], 0);
    req = 4'b0000;
    wait_until("idle6", 2, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      req = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cfg_seed_valid = ($urandom_range(0, 29) == 0);
      cfg_seed = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    req = 4'b0000;
    cfg_seed_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_until("drain", 2, 0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
